// File: rtl/imem_loader.sv
// imem_loader
//   Streams a program image from a byte source into instruction memory while
//   holding the CPU frozen and in reset. Stream format:
//     len_hi, len_lo (word count N), N x 4 data bytes (MSB first), checksum
//   The checksum byte must equal the XOR of every preceding byte in the session.
//   On a good checksum the CPU is released (freeze/cpu_rst low, done high);
//   otherwise the loader parks in ERR. Words already written stay written.
//
// Ports
//   clk         clock, all state changes on the rising edge
//   rst         asynchronous reset, active low
//   start       one-cycle request to open a load session (IDLE/DONE/ERR only)
//   byte_valid  byte_data carries a stream byte
//   byte_data   stream byte
//   byte_ready  loader takes a byte this cycle when byte_valid is also high
//   imem_we     one-cycle instruction-memory write strobe
//   imem_addr   word address of the write
//   imem_wdata  instruction word of the write
//   freeze      fetch-stage freeze, low only in DONE
//   cpu_rst     active-high pipeline reset, low only in DONE
//   done        load finished with a good checksum
//   err         load aborted (bad length or bad checksum)
module imem_loader #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          byte_valid,
    input  logic [7:0]    byte_data,
    output logic          byte_ready,
    output logic          imem_we,
    output logic [AW-1:0] imem_addr,
    output logic [31:0]   imem_wdata,
    output logic          freeze,
    output logic          cpu_rst,
    output logic          done,
    output logic          err
);

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA,
        CHECK,
        DONE,
        ERR
    } state_t;

    state_t        r_state;
    state_t        w_next;

    logic [7:0]    r_len_hi;
    logic [15:0]   r_len;
    logic [AW-1:0] r_word_idx;
    logic [1:0]    r_byte_idx;
    logic [7:0]    r_csum;
    // Only the first three bytes of a word need holding; the fourth goes
    // straight into the write-data register together with these.
    logic [23:0]   r_asm;

    logic          r_byte_ready;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [31:0]   r_wdata;
    logic          r_freeze;
    logic          r_cpu_rst;
    logic          r_done;
    logic          r_err;

    logic          w_accept;
    logic          w_open;
    logic [15:0]   w_len;
    logic          w_len_bad;
    logic          w_last_word;

    assign w_accept    = byte_valid && r_byte_ready;
    assign w_open      = start && (r_state == IDLE || r_state == DONE || r_state == ERR);
    assign w_len       = {r_len_hi, byte_data};
    assign w_len_bad   = (w_len == 16'd0) || (32'(w_len) > 32'(DEPTH));
    // Compared one bit wider than the length so AW = 16 still works.
    assign w_last_word = (17'(r_word_idx) + 17'd1) == 17'(r_len);

    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, DONE, ERR: if (start)    w_next = LEN_HI;
            LEN_HI:          if (w_accept) w_next = LEN_LO;
            LEN_LO:          if (w_accept) w_next = w_len_bad ? ERR : DATA;
            DATA:            if (w_accept && r_byte_idx == 2'd3 && w_last_word) w_next = CHECK;
            CHECK:           if (w_accept) w_next = (byte_data == r_csum) ? DONE : ERR;
            default:         w_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_len_hi     <= '0;
            r_len        <= '0;
            r_word_idx   <= '0;
            r_byte_idx   <= '0;
            r_csum       <= '0;
            r_asm        <= '0;
            r_byte_ready <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_freeze     <= 1'b1;
            r_cpu_rst    <= 1'b1;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state <= w_next;
            r_we    <= 1'b0;

            // Outputs are decoded from the next state so they line up with it.
            r_byte_ready <= (w_next == LEN_HI) || (w_next == LEN_LO) ||
                            (w_next == DATA)   || (w_next == CHECK);
            r_freeze     <= (w_next != DONE);
            r_cpu_rst    <= (w_next != DONE);
            r_done       <= (w_next == DONE);
            r_err        <= (w_next == ERR);

            if (w_open) begin
                r_word_idx <= '0;
                r_byte_idx <= '0;
                r_csum     <= '0;
            end

            if (w_accept) begin
                if (r_state != CHECK) begin
                    r_csum <= r_csum ^ byte_data;
                end
                case (r_state)
                    LEN_HI: r_len_hi <= byte_data;
                    LEN_LO: begin
                        r_len      <= w_len;
                        r_word_idx <= '0;
                        r_byte_idx <= '0;
                    end
                    DATA: begin
                        r_asm      <= {r_asm[15:0], byte_data};
                        r_byte_idx <= r_byte_idx + 2'd1;
                        if (r_byte_idx == 2'd3) begin
                            r_we    <= 1'b1;
                            r_addr  <= r_word_idx;
                            r_wdata <= {r_asm, byte_data};
                            // Parks on the last word instead of wrapping.
                            if (!w_last_word) begin
                                r_word_idx <= r_word_idx + AW'(1);
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign byte_ready = r_byte_ready;
    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign freeze     = r_freeze;
    assign cpu_rst    = r_cpu_rst;
    assign done       = r_done;
    assign err        = r_err;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table of complete load streams plus
// hand-written sequences for reset mid-session, gapped streams with stray
// start pulses, and a full-depth load.
module tb_imem_loader;

    localparam int DEPTH = 1024;
    localparam int AW    = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          byte_valid = 1'b0;
    logic [7:0]    byte_data = 8'h00;
    logic          byte_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          freeze;
    logic          cpu_rst;
    logic          done;
    logic          err;

    imem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .freeze     (freeze),
        .cpu_rst    (cpu_rst),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    wr_t wq[$];

    // imem_we is high for a whole cycle, so one falling edge sees each pulse once.
    always @(negedge clk) begin
        if (rst && imem_we === 1'b1) wq.push_back('{addr: imem_addr, data: imem_wdata});
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            byte_valid = 1'b0;
            start      = 1'b0;
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        byte_valid = 1'b0;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
    endtask

    // Presents one byte after 'gap' idle cycles; 'st' raises start alongside it.
    task automatic send_byte(input logic [7:0] b, input int gap, input logic st);
        int k;
        idle(gap);
        @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
        start      = st;
        k = 0;
        while (byte_ready !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (k == 20) begin
            n_checks++;
            n_errors++;
            $display("FAIL send_byte_timeout: byte_ready stuck at %b expected 1", byte_ready);
        end
        @(posedge clk);
    endtask

    task automatic check_status(input string tag, input logic exp_done);
        check({tag, "_done"},    32'(done),       32'(exp_done));
        check({tag, "_err"},     32'(err),        32'(!exp_done));
        check({tag, "_freeze"},  32'(freeze),     32'(!exp_done));
        check({tag, "_cpu_rst"}, 32'(cpu_rst),    32'(!exp_done));
        check({tag, "_ready"},   32'(byte_ready), 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ready"},   32'(byte_ready), 32'd0);
        check({tag, "_we"},      32'(imem_we),    32'd0);
        check({tag, "_addr"},    32'(imem_addr),  32'd0);
        check({tag, "_wdata"},   imem_wdata,      32'd0);
        check({tag, "_freeze"},  32'(freeze),     32'd1);
        check({tag, "_cpu_rst"}, 32'(cpu_rst),    32'd1);
        check({tag, "_done"},    32'(done),       32'd0);
        check({tag, "_err"},     32'(err),        32'd0);
    endtask

    task automatic check_good_writes(input string tag);
        check({tag, "_nwr"}, 32'(wq.size()), 32'd2);
        if (wq.size() > 0) begin
            check({tag, "_a0"}, 32'(wq[0].addr), 32'd0);
            check({tag, "_d0"}, wq[0].data, 32'h8001600A);
        end
        if (wq.size() > 1) begin
            check({tag, "_a1"}, 32'(wq[1].addr), 32'd1);
            check({tag, "_d1"}, wq[1].data, 32'h04011000);
        end
    endtask

    typedef struct {
        string            name;
        int               nbytes;
        logic [0:10][7:0] stream;
        int               n_wr;
        logic [31:0]      w0;
        logic [31:0]      w1;
        logic             exp_done;
    } vec_t;

    vec_t vecs[5];

    logic [0:10][7:0] good_stream;

    function automatic logic [31:0] bulk_word(input int w);
        return (32'(w) * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    initial begin
        good_stream = {8'h00, 8'h02, 8'h80, 8'h01, 8'h60, 8'h0A,
                       8'h04, 8'h01, 8'h10, 8'h00, 8'hFC};

        vecs[0] = '{"good", 11, {8'h00, 8'h02, 8'h80, 8'h01, 8'h60, 8'h0A,
                                 8'h04, 8'h01, 8'h10, 8'h00, 8'hFC},
                    2, 32'h8001600A, 32'h04011000, 1'b1};
        vecs[1] = '{"badsum", 11, {8'h00, 8'h02, 8'h80, 8'h01, 8'h60, 8'h0A,
                                   8'h04, 8'h01, 8'h10, 8'h00, 8'hFD},
                    2, 32'h8001600A, 32'h04011000, 1'b0};
        vecs[2] = '{"len0", 2, {8'h00, 8'h00, 72'h0}, 0, 32'h0, 32'h0, 1'b0};
        vecs[3] = '{"len1025", 2, {8'h04, 8'h01, 72'h0}, 0, 32'h0, 32'h0, 1'b0};
        // 00^01^DE^AD^BE^EF = 23
        vecs[4] = '{"oneword", 7, {8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h23, 32'h0},
                    1, 32'hDEADBEEF, 32'h0, 1'b1};

        // Reset state
        #12;
        check_reset_values("por");
        @(negedge clk);
        rst = 1'b1;
        idle(2);
        check("idle_ready", 32'(byte_ready), 32'd0);
        check("idle_freeze", 32'(freeze), 32'd1);

        // Table of complete sessions
        for (int i = 0; i < 5; i++) begin
            pulse_start();
            check({vecs[i].name, "_ready_after_start"}, 32'(byte_ready), 32'd1);
            check({vecs[i].name, "_clear_done"}, 32'(done), 32'd0);
            check({vecs[i].name, "_clear_err"}, 32'(err), 32'd0);
            wq.delete();
            for (int j = 0; j < vecs[i].nbytes; j++) send_byte(vecs[i].stream[j], 0, 1'b0);
            idle(2);
            check_status(vecs[i].name, vecs[i].exp_done);
            check({vecs[i].name, "_nwr"}, 32'(wq.size()), 32'(vecs[i].n_wr));
            if (vecs[i].n_wr >= 1 && wq.size() > 0) begin
                check({vecs[i].name, "_a0"}, 32'(wq[0].addr), 32'd0);
                check({vecs[i].name, "_d0"}, wq[0].data, vecs[i].w0);
            end
            if (vecs[i].n_wr >= 2 && wq.size() > 1) begin
                check({vecs[i].name, "_a1"}, 32'(wq[1].addr), 32'd1);
                check({vecs[i].name, "_d1"}, wq[1].data, vecs[i].w1);
            end
        end

        // Reset in DATA after five bytes, then a fresh load
        pulse_start();
        for (int j = 0; j < 5; j++) send_byte(good_stream[j], 0, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        check_reset_values("rst_mid");
        @(negedge clk);
        byte_valid = 1'b0;
        rst = 1'b1;
        idle(3);
        check("rst_no_resume_ready", 32'(byte_ready), 32'd0);
        check("rst_no_resume_done", 32'(done), 32'd0);
        pulse_start();
        wq.delete();
        for (int j = 0; j < 11; j++) send_byte(good_stream[j], 0, 1'b0);
        idle(2);
        check_status("after_rst", 1'b1);
        check_good_writes("after_rst");

        // Random idle gaps with stray start pulses inside the session
        pulse_start();
        wq.delete();
        for (int j = 0; j < 11; j++) send_byte(good_stream[j], $urandom_range(0, 3), (j % 3) == 1);
        idle(2);
        check_status("gaps", 1'b1);
        check_good_writes("gaps");

        // Full-depth load
        begin
            logic [7:0]  csum;
            logic [31:0] w;
            int          bad;
            pulse_start();
            wq.delete();
            csum = 8'h00;
            send_byte(8'h04, 0, 1'b0);
            csum ^= 8'h04;
            send_byte(8'h00, 0, 1'b0);
            for (int i = 0; i < DEPTH; i++) begin
                w = bulk_word(i);
                for (int b = 3; b >= 0; b--) begin
                    send_byte(w[8*b +: 8], 0, 1'b0);
                    csum ^= w[8*b +: 8];
                end
            end
            send_byte(csum, 0, 1'b0);
            idle(2);
            check_status("full", 1'b1);
            check("full_nwr", 32'(wq.size()), 32'(DEPTH));
            if (wq.size() > 0) check("full_last_addr", 32'(wq[wq.size()-1].addr), 32'h3FF);
            bad = 0;
            foreach (wq[k]) begin
                if (32'(wq[k].addr) != 32'(k) || wq[k].data !== bulk_word(k)) bad++;
            end
            check("full_bad_entries", 32'(bad), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
